multi_dataflow_core: RTL and testbench

// - Merged two-configuration dataflow kernel: two 32-bit input token streams, two 32-bit output streams.
// - Runtime select ID picks the active dataflow: ID=1 "top" (add/sub), ID=2 "top1" (mul/xor).
// - Input side uses FIFO-write handshake (data/full_n/write). Output side drives a downstream FIFO the same way.

---
 rtl/multi_dataflow_core_if.sv | 12 +
 rtl/multi_dataflow_core.sv | 141 ++++++++++++++
 tb/tb_multi_dataflow_core.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_dataflow_core_if.sv
// FIFO-write style token stream: producer drives data/write, consumer answers with full_n.
// A token moves on a rising edge where write=1 and full_n=1.
interface multi_dataflow_core_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              full_n;
  logic              write;

  modport master (output data, output write, input  full_n);
  modport slave  (input  data, input  write, output full_n);
endinterface

// File: rtl/multi_dataflow_core.sv
// Two-configuration dataflow kernel: ID=1 add/sub, ID=2 mul/xor on paired tokens from in0/in1.
// Define MULTI_DATAFLOW_PASSTHRU_EN to add ID=3 (out0=a, out1=b).
module multi_dataflow_core #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  multi_dataflow_core_if.slave          in0,
  multi_dataflow_core_if.slave          in1,
  multi_dataflow_core_if.master         out0,
  multi_dataflow_core_if.master         out1,
  input  logic [7:0]                    ID
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [1:0]              wr_req;
  logic [1:0]              push;
  logic [1:0]              full_n;
  logic [1:0]              nonempty;
  logic [1:0]              out_ready;
  logic [1:0]              out_valid;
  logic [1:0]              slot_free;
  logic [1:0][DATA_W-1:0]  wr_data;
  logic [1:0][DATA_W-1:0]  head;
  logic [1:0][DATA_W-1:0]  res;
  logic [1:0][DATA_W-1:0]  out_data;
  logic                    id_ok;
  logic                    fire;

  assign wr_req     = {in1.write, in0.write};
  assign wr_data[0] = in0.data;
  assign wr_data[1] = in1.data;
  assign in0.full_n = full_n[0];
  assign in1.full_n = full_n[1];

  // full_n is a register, so a write seen while it is low is simply dropped.
  assign push = wr_req & full_n;

  assign out_ready = {out1.full_n, out0.full_n};
  assign slot_free = ~out_valid | out_ready;
  assign fire      = (&nonempty) & id_ok & (&slot_free);

  always_comb begin
    id_ok  = 1'b0;
    res[0] = '0;
    res[1] = '0;
    case (ID)
      8'd1: begin
        id_ok  = 1'b1;
        res[0] = head[0] + head[1];
        res[1] = head[0] - head[1];
      end
      8'd2: begin
        id_ok  = 1'b1;
        res[0] = head[0] * head[1];
        res[1] = head[0] ^ head[1];
      end
`ifdef MULTI_DATAFLOW_PASSTHRU_EN
      8'd3: begin
        id_ok  = 1'b1;
        res[0] = head[0];
        res[1] = head[1];
      end
`endif
      default: ;
    endcase
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              full_n_q;

    assign head[ch]     = mem[rd_ptr];
    assign nonempty[ch] = (count != '0);
    assign full_n[ch]   = full_n_q;

    always_comb begin
      count_nxt = count;
      if (push[ch] && !fire)
        count_nxt = count + 1'b1;
      else if (!push[ch] && fire)
        count_nxt = count - 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        full_n_q <= 1'b1;
      end else begin
        if (push[ch])
          wr_ptr <= wr_ptr + 1'b1;
        if (fire)
          rd_ptr <= rd_ptr + 1'b1;
        count    <= count_nxt;
        full_n_q <= (count_nxt != FULL_CNT);
      end
    end

    always_ff @(posedge ap_clk) begin
      if (push[ch])
        mem[wr_ptr] <= wr_data[ch];
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_slot
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign out_valid[ch] = valid_q;
    assign out_data[ch]  = data_q;

    // A reload in the same cycle as a transfer keeps the slot occupied.
    always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (fire) begin
        valid_q <= 1'b1;
        data_q  <= res[ch];
      end else if (valid_q && out_ready[ch]) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out0.data  = out_data[0];
  assign out1.data  = out_data[1];
  assign out0.write = out_valid[0] & out0.full_n;
  assign out1.write = out_valid[1] & out1.full_n;

endmodule

// File: tb/tb_multi_dataflow_core.sv
// Self-checking bench for multi_dataflow_core: directed vectors plus randomized streams
// scored against a queue-based pairing model of the two configurations.
module tb_multi_dataflow_core;

  localparam int DEPTH = 4;

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b0;
  logic [7:0] ID     = 8'd0;

  int tests_run    = 0;
  int tests_failed = 0;

  multi_dataflow_core_if #(.DATA_W(32)) in0_if ();
  multi_dataflow_core_if #(.DATA_W(32)) in1_if ();
  multi_dataflow_core_if #(.DATA_W(32)) out0_if ();
  multi_dataflow_core_if #(.DATA_W(32)) out1_if ();

  multi_dataflow_core #(.DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .in0    (in0_if),
    .in1    (in1_if),
    .out0   (out0_if),
    .out1   (out1_if),
    .ID     (ID)
  );

  always #5 ap_clk = ~ap_clk;

  // Observed accepted inputs and transferred outputs, sampled mid-cycle.
  logic [31:0] qa[$], qb[$], got0[$], got1[$];

  always @(negedge ap_clk) begin
    if (ap_rst === 1'b1) begin
      if (in0_if.write && in0_if.full_n) qa.push_back(in0_if.data);
      if (in1_if.write && in1_if.full_n) qb.push_back(in1_if.data);
      if (out0_if.write) got0.push_back(out0_if.data);
      if (out1_if.write) got1.push_back(out1_if.data);
    end
  end

  function automatic logic [31:0] ref_out(input int k, input logic [7:0] id,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (id)
      8'd1: return (k == 0) ? a + b : a - b;
      8'd2: return (k == 0) ? p[31:0] : a ^ b;
`ifdef MULTI_DATAFLOW_PASSTHRU_EN
      8'd3: return (k == 0) ? a : b;
`endif
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic clear_model();
    qa.delete(); qb.delete(); got0.delete(); got1.delete();
  endtask

  task automatic drive_stream(input int which, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      int  gap;
      bit  seen;
      gap  = (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
      repeat (gap) begin @(posedge ap_clk); #2; end
      if (which == 0) begin in0_if.data = $urandom; in0_if.write = 1'b1; end
      else            begin in1_if.data = $urandom; in1_if.write = 1'b1; end
      seen = 1'b0;
      for (int w = 0; w < 200 && !seen; w++) begin
        @(negedge ap_clk);
        seen = (which == 0) ? (in0_if.full_n === 1'b1) : (in1_if.full_n === 1'b1);
      end
      @(posedge ap_clk); #2;
      if (which == 0) in0_if.write = 1'b0; else in1_if.write = 1'b0;
      if (!seen) begin
        tests_run++; tests_failed++;
        $display("FAIL in%0d_accept: full_n stayed 0 for 200 cycles, required 1", which);
        return;
      end
    end
  endtask

  task automatic wait_drain(input int n);
    int c = 0;
    while ((got0.size() < n || got1.size() < n) && c < 3000) begin
      @(posedge ap_clk); c++;
    end
    @(posedge ap_clk); #2;
    if (c >= 3000) begin
      tests_run++; tests_failed++;
      $display("FAIL drain_timeout: got %0d/%0d results, required %0d", got0.size(), got1.size(), n);
    end
  endtask

  task automatic test_reset();
    in0_if.data = '0; in0_if.write = 1'b0;
    in1_if.data = '0; in1_if.write = 1'b0;
    out0_if.full_n = 1'b1; out1_if.full_n = 1'b1;
    ap_rst = 1'b0;
    #50;
    tests_run++;
    if ({in0_if.full_n, in1_if.full_n, out0_if.write, out1_if.write} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_during: full_n/write = %b, required 1100",
               {in0_if.full_n, in1_if.full_n, out0_if.write, out1_if.write});
    end
    tests_run++;
    if ({out0_if.data, out1_if.data} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_data: out0=%h out1=%h, required 0", out0_if.data, out1_if.data);
    end
    #50 ap_rst = 1'b1;
    @(posedge ap_clk); #2;
    tests_run++;
    if ({in0_if.full_n, in1_if.full_n, out0_if.write, out1_if.write} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_after: full_n/write = %b, required 1100",
               {in0_if.full_n, in1_if.full_n, out0_if.write, out1_if.write});
    end
  endtask

  task automatic test_directed();
    logic [7:0]  ids [4] = '{8'd1, 8'd1, 8'd2, 8'd2};
    logic [31:0] va  [4] = '{32'd5, 32'hFFFF_FFFF, 32'd6, 32'h0001_0000};
    logic [31:0] vb  [4] = '{32'd3, 32'd1, 32'd7, 32'h0001_0000};
    logic [31:0] e0  [4] = '{32'd8, 32'd0, 32'd42, 32'd0};
    logic [31:0] e1  [4] = '{32'd2, 32'hFFFF_FFFE, 32'd1, 32'd0};
    for (int i = 0; i < 4; i++) begin
      ID = ids[i];
      in0_if.data = va[i]; in1_if.data = vb[i];
      in0_if.write = 1'b1; in1_if.write = 1'b1;
      @(posedge ap_clk); #2;
      in0_if.write = 1'b0; in1_if.write = 1'b0;
      @(negedge ap_clk);
      tests_run++;
      if ({out0_if.write, out1_if.write} !== 2'b00) begin
        tests_failed++;
        $display("FAIL directed%0d_early: write=%b one cycle after input, required 00",
                 i, {out0_if.write, out1_if.write});
      end
      @(negedge ap_clk);
      tests_run++;
      if (out0_if.write !== 1'b1 || out1_if.write !== 1'b1 ||
          out0_if.data !== e0[i] || out1_if.data !== e1[i]) begin
        tests_failed++;
        $display("FAIL directed%0d: write=%b out0=%h out1=%h, required 11 %h %h",
                 i, {out0_if.write, out1_if.write}, out0_if.data, out1_if.data, e0[i], e1[i]);
      end
      @(posedge ap_clk); #2;
    end
  endtask

  task automatic test_stream();
    bit done = 1'b0;
    ID = 8'd1;
    clear_model();
    fork
      begin
        fork
          drive_stream(0, 64, 3);
          drive_stream(1, 64, 3);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge ap_clk); #2;
          out0_if.full_n = ($urandom_range(3, 0) != 0);
          out1_if.full_n = ($urandom_range(3, 0) != 0);
        end
        out0_if.full_n = 1'b1; out1_if.full_n = 1'b1;
      end
    join
    wait_drain(64);
    tests_run++;
    if (got0.size() != 64 || got1.size() != 64 || qa.size() != 64 || qb.size() != 64) begin
      tests_failed++;
      $display("FAIL stream_count: in %0d/%0d out %0d/%0d, required 64 each",
               qa.size(), qb.size(), got0.size(), got1.size());
    end
    for (int i = 0; i < 64; i++) begin
      tests_run++;
      if (i >= got0.size() || i >= got1.size() || i >= qa.size() || i >= qb.size()) begin
        tests_failed++;
        $display("FAIL stream[%0d]: result missing", i);
      end else if (got0[i] !== ref_out(0, 8'd1, qa[i], qb[i]) ||
                   got1[i] !== ref_out(1, 8'd1, qa[i], qb[i])) begin
        tests_failed++;
        $display("FAIL stream[%0d]: got %h %h, required %h %h", i, got0[i], got1[i],
                 ref_out(0, 8'd1, qa[i], qb[i]), ref_out(1, 8'd1, qa[i], qb[i]));
      end
    end
  endtask

  task automatic test_full();
    ID = 8'd1;
    clear_model();
    drive_stream(0, DEPTH, 0);
    tests_run++;
    if (in0_if.full_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_assert: in0_full_n=%b, required 0", in0_if.full_n);
    end
    // Write into a full buffer: must be dropped.
    in0_if.data = 32'hDEAD_BEEF; in0_if.write = 1'b1;
    @(posedge ap_clk); #2;
    in0_if.write = 1'b0;
    tests_run++;
    if (qa.size() != DEPTH) begin
      tests_failed++;
      $display("FAIL full_drop: accepted %0d, required %0d", qa.size(), DEPTH);
    end
    in1_if.data = $urandom; in1_if.write = 1'b1;
    @(posedge ap_clk); #2;
    in1_if.write = 1'b0;
    @(negedge ap_clk);
    tests_run++;
    if (in0_if.full_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_hold: in0_full_n=%b before firing, required 0", in0_if.full_n);
    end
    @(negedge ap_clk);
    tests_run++;
    if (in0_if.full_n !== 1'b1 || out0_if.write !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_release: in0_full_n=%b out0_write=%b, required 1 1",
               in0_if.full_n, out0_if.write);
    end
    @(posedge ap_clk); #2;
    drive_stream(1, DEPTH - 1, 0);
    wait_drain(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (i >= got0.size() || i >= got1.size() || i >= qa.size() || i >= qb.size()) begin
        tests_failed++;
        $display("FAIL full[%0d]: result missing", i);
      end else if (got0[i] !== ref_out(0, 8'd1, qa[i], qb[i]) ||
                   got1[i] !== ref_out(1, 8'd1, qa[i], qb[i])) begin
        tests_failed++;
        $display("FAIL full[%0d]: got %h %h, required %h %h", i, got0[i], got1[i],
                 ref_out(0, 8'd1, qa[i], qb[i]), ref_out(1, 8'd1, qa[i], qb[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    ID = 8'd1;
    clear_model();
    out0_if.full_n = 1'b0; out1_if.full_n = 1'b1;
    fork
      drive_stream(0, 16, 0);
      drive_stream(1, 16, 0);
      begin
        logic [31:0] held;
        held = '0;
        for (int i = 0; i < 10; i++) begin
          @(negedge ap_clk);
          tests_run++;
          if (out0_if.write !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_write[%0d]: out0_write=%b, required 0", i, out0_if.write);
          end
          if (i == 3) held = out0_if.data;
          if (i > 3) begin
            tests_run++;
            if (out0_if.data !== held) begin
              tests_failed++;
              $display("FAIL bp_stable[%0d]: out0_data=%h, required %h", i, out0_if.data, held);
            end
          end
        end
        @(posedge ap_clk); #2;
        tests_run++;
        if (got1.size() > 1 || got0.size() != 0) begin
          tests_failed++;
          $display("FAIL bp_drain: out1 moved %0d out0 moved %0d, required <=1 and 0",
                   got1.size(), got0.size());
        end
        out0_if.full_n = 1'b1;
      end
    join
    wait_drain(16);
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (i >= got0.size() || i >= got1.size() || i >= qa.size() || i >= qb.size()) begin
        tests_failed++;
        $display("FAIL bp[%0d]: result missing", i);
      end else if (got0[i] !== ref_out(0, 8'd1, qa[i], qb[i]) ||
                   got1[i] !== ref_out(1, 8'd1, qa[i], qb[i])) begin
        tests_failed++;
        $display("FAIL bp[%0d]: got %h %h, required %h %h", i, got0[i], got1[i],
                 ref_out(0, 8'd1, qa[i], qb[i]), ref_out(1, 8'd1, qa[i], qb[i]));
      end
    end
  endtask

  task automatic test_id_switch();
    ID = 8'd0;
    clear_model();
    fork
      drive_stream(0, 3, 1);
      drive_stream(1, 3, 1);
    join
    repeat (10) @(posedge ap_clk);
`ifndef MULTI_DATAFLOW_PASSTHRU_EN
    ID = 8'd3;
    repeat (10) @(posedge ap_clk);
`endif
    #2;
    tests_run++;
    if (got0.size() != 0 || got1.size() != 0) begin
      tests_failed++;
      $display("FAIL id_invalid: %0d/%0d outputs with invalid ID, required 0",
               got0.size(), got1.size());
    end
    ID = 8'd2;
    wait_drain(3);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= got0.size() || i >= got1.size() || i >= qa.size() || i >= qb.size()) begin
        tests_failed++;
        $display("FAIL id_switch[%0d]: result missing", i);
      end else if (got0[i] !== ref_out(0, 8'd2, qa[i], qb[i]) ||
                   got1[i] !== ref_out(1, 8'd2, qa[i], qb[i])) begin
        tests_failed++;
        $display("FAIL id_switch[%0d]: got %h %h, required %h %h", i, got0[i], got1[i],
                 ref_out(0, 8'd2, qa[i], qb[i]), ref_out(1, 8'd2, qa[i], qb[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    ID = 8'd0;
    clear_model();
    fork
      drive_stream(0, DEPTH, 0);
      drive_stream(1, 2, 0);
    join
    tests_run++;
    if (in0_if.full_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_full: in0_full_n=%b before reset, required 0", in0_if.full_n);
    end
    #1 ap_rst = 1'b0;
    #1;
    tests_run++;
    if ({in0_if.full_n, in1_if.full_n, out0_if.write, out1_if.write} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL rmid_async: full_n/write = %b, required 1100",
               {in0_if.full_n, in1_if.full_n, out0_if.write, out1_if.write});
    end
    @(posedge ap_clk); #2;
    ap_rst = 1'b1;
    ID = 8'd1;
    clear_model();
    repeat (10) @(posedge ap_clk);
    #2;
    tests_run++;
    if (got0.size() != 0 || got1.size() != 0) begin
      tests_failed++;
      $display("FAIL rmid_discard: %0d/%0d outputs after reset, required 0",
               got0.size(), got1.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_full();
    test_backpressure();
    test_id_switch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
